// File: rtl/data_mem_if.sv
// Load/store port between the core's MEM stage and the data-memory responder.
// The core drives the request side and the responder drives the response side.
interface data_mem_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_funct3,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_funct3,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store port.
// Accepts one request at a time, waits WAIT_CYCLES, then commits the access
// and presents a single-cycle response with sign/zero-extended load data.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; req_ready=1
// ST_WAIT | request latched, counting down wait states
// ST_RESP | access committed on entry; resp_valid=1 for this cycle
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus,
    output logic       busy
);

    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW         = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [32:0]     BYTE_LIMIT = 33'(4 * DEPTH);
    localparam logic [CW-1:0]   WAIT_LOAD  = CW'(WAIT_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;

    logic           lat_we;
    logic [31:0]    lat_addr;
    logic [31:0]    lat_wdata;
    logic [2:0]     lat_funct3;

    logic           accept;
    logic           commit;

    // Operand view used at the commit edge. With zero wait states the commit
    // edge is the accept edge, so the live bus must be used instead of the
    // latched copy, which only becomes valid after that edge.
    logic           op_we;
    logic [31:0]    op_addr;
    logic [31:0]    op_wdata;
    logic [2:0]     op_funct3;
    logic [1:0]     op_size;
    logic           op_err;
    logic           f3_legal;
    logic           misaligned;
    logic           out_of_range;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  word_idx;
    logic [31:0]    rd_word;
    logic [7:0]     rd_byte;
    logic [15:0]    rd_half;
    logic [31:0]    load_data;
    logic [3:0]     wr_be;
    logic [31:0]    wr_lanes;

    logic [31:0]    rdata_q;
    logic           err_q;

    assign accept = bus.req_valid && (state_q == ST_IDLE);
    assign commit = (state_d == ST_RESP) && (state_q != ST_RESP);

    // Pick the live request in IDLE (zero-wait commit) and the latched copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_we     = bus.req_we;
            op_addr   = bus.req_addr;
            op_wdata  = bus.req_wdata;
            op_funct3 = bus.req_funct3;
        end else begin
            op_we     = lat_we;
            op_addr   = lat_addr;
            op_wdata  = lat_wdata;
            op_funct3 = lat_funct3;
        end
    end

    assign op_size  = op_funct3[1:0];
    assign word_idx = op_addr[AW+1:2];
    assign rd_word  = mem[word_idx];

    // Fault decode: illegal funct3 for the direction, misalignment, or address past the array.
    always_comb begin
        f3_legal     = 1'b0;
        misaligned   = 1'b0;
        out_of_range = ({1'b0, op_addr} >= BYTE_LIMIT);
        if (op_we) begin
            f3_legal = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) ||
                       (op_funct3 == 3'b010);
        end else begin
            f3_legal = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) ||
                       (op_funct3 == 3'b010) || (op_funct3 == 3'b100) ||
                       (op_funct3 == 3'b101);
        end
        case (op_size)
            SZ_HALF: misaligned = op_addr[0];
            SZ_WORD: misaligned = (op_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        op_err = !f3_legal || misaligned || out_of_range;
    end

    // Lane extraction and sign/zero extension for loads; funct3[2] selects unsigned.
    always_comb begin
        rd_byte   = 8'h00;
        rd_half   = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = 32'h0;
        case (op_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (op_size)
            SZ_BYTE: load_data = {{24{!op_funct3[2] && rd_byte[7]}}, rd_byte};
            SZ_HALF: load_data = {{16{!op_funct3[2] && rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Byte enables and replicated store data so every lane sees its own slice.
    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = op_wdata;
        case (op_size)
            SZ_BYTE: begin
                wr_be    = 4'b0001 << op_addr[1:0];
                wr_lanes = {4{op_wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be    = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{op_wdata[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = op_wdata;
            end
        endcase
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch; reset on the accept edge wins so nothing is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_funct3 <= 3'b000;
        end else if (accept) begin
            lat_we     <= bus.req_we;
            lat_addr   <= bus.req_addr;
            lat_wdata  <= bus.req_wdata;
            lat_funct3 <= bus.req_funct3;
        end
    end

    // Response data captured on the edge entering RESP; stores and faults return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (commit) begin
            rdata_q <= (op_err || op_we) ? 32'h0 : load_data;
            err_q   <= op_err;
        end
    end

    // Storage write on the RESP-entry edge; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        busy           = 1'b0;
        case (state_q)
            ST_IDLE: bus.req_ready = 1'b1;
            ST_WAIT: busy = 1'b1;
            ST_RESP: begin
                busy           = 1'b1;
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
            end
            default: bus.req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int DEPTH2 = 1024;
    localparam int DEPTH0 = 64;

    logic clk = 1'b0;
    logic rst2;
    logic rst0;
    logic busy2;
    logic busy0;

    int checks   = 0;
    int failures = 0;

    // byte-addressed reference store for the WAIT_CYCLES=2 instance
    logic [7:0] mdl [int unsigned];

    data_mem_if bus2 ();
    data_mem_if bus0 ();

    data_mem_responder #(.DEPTH(DEPTH2), .WAIT_CYCLES(2)) dut2 (
        .clk  (clk),
        .rst  (rst2),
        .bus  (bus2.slave),
        .busy (busy2)
    );

    data_mem_responder #(.DEPTH(DEPTH0), .WAIT_CYCLES(0)) dut0 (
        .clk  (clk),
        .rst  (rst0),
        .bus  (bus0.slave),
        .busy (busy0)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    // Reference behaviour from the access rules: legality, alignment, range,
    // then byte-level store/load with extension.
    function automatic void model_access(input logic we, input logic [31:0] a,
                                         input logic [31:0] wd, input logic [2:0] f3,
                                         output logic [31:0] rd, output logic er);
        int n;
        logic legal;
        logic mis;
        logic oor;
        logic [31:0] v;
        logic [31:0] mask;
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (a % n) != 0;
        oor   = a >= 32'(4 * DEPTH2);
        er    = !legal || mis || oor;
        rd    = 32'h0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < n; i++) mdl[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | ({24'h0, mdl[a + i]} << (8 * i));
            if (!f3[2] && n < 4 && v[8*n-1]) begin
                mask = (32'd1 << (8 * n)) - 32'd1;
                v = v | ~mask;
            end
            rd = v;
        end
    endfunction

    // One request on the WAIT_CYCLES=2 instance, observed over a fixed window.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                          output int lat, output int nresp, output logic rdy_ok);
        @(negedge clk);
        rdy_ok = bus2.req_ready;
        bus2.req_valid  = 1'b1;
        bus2.req_we     = we;
        bus2.req_addr   = addr;
        bus2.req_wdata  = wdata;
        bus2.req_funct3 = f3;
        @(posedge clk);
        #1;
        bus2.req_valid  = 1'b0;
        bus2.req_we     = 1'($urandom);
        bus2.req_addr   = $urandom;
        bus2.req_wdata  = $urandom;
        bus2.req_funct3 = 3'($urandom);
        lat = -1;
        nresp = 0;
        rdata = 32'h0;
        err = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus2.resp_valid) begin
                nresp++;
                if (lat < 0) begin
                    lat   = k;
                    rdata = bus2.resp_rdata;
                    err   = bus2.resp_err;
                end
            end
            if (bus2.req_ready && (lat < 0 || bus2.resp_valid)) rdy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0;
        bus2.req_wdata = '0;   bus2.req_funct3 = '0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_funct3 = '0;
        rst2 = 1'b1;
        rst0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus2.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus2.req_ready); end
        checks++; if (bus2.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus2.resp_valid); end
        checks++; if (bus2.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus2.resp_rdata); end
        checks++; if (bus2.resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus2.resp_err); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy2); end
        rst2 = 1'b0;
        rst0 = 1'b0;
    endtask

    task automatic test_store_timing();
        logic [31:0] rd, erd;
        logic er, eer, rdy;
        int lat, nr;
        model_access(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, erd, eer);
        access(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, rd, er, lat, nr, rdy);
        checks++; if (lat !== 3) begin failures++; $display("FAIL sw_latency got=%0d exp=3", lat); end
        checks++; if (nr !== 1) begin failures++; $display("FAIL sw_resp_count got=%0d exp=1", nr); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL sw_ready_low got=%b exp=1", rdy); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sw_rdata got=%h exp=0", rd); end
    endtask

    task automatic test_loads();
        logic [31:0] rd, erd;
        logic er, eer, rdy;
        int lat, nr;
        logic [2:0]  f3s [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [5] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] exps[5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 5; i++) begin
            model_access(1'b0, ads[i], 32'h0, f3s[i], erd, eer);
            access(1'b0, ads[i], 32'h0, f3s[i], rd, er, lat, nr, rdy);
            checks++;
            if (rd !== exps[i] || er !== 1'b0) begin
                failures++;
                $display("FAIL load_%0d got=%h err=%b exp=%h err=0", i, rd, er, exps[i]);
            end
        end
    endtask

    task automatic test_sub_word_stores();
        logic [31:0] rd, erd;
        logic er, eer, rdy;
        int lat, nr;
        model_access(1'b1, 32'h101, 32'h12345655, 3'b000, erd, eer);
        access(1'b1, 32'h101, 32'h12345655, 3'b000, rd, er, lat, nr, rdy);
        model_access(1'b0, 32'h100, 32'h0, 3'b010, erd, eer);
        access(1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat, nr, rdy);
        checks++; if (rd !== 32'hDEAD55EF) begin failures++; $display("FAIL sb_then_lw got=%h exp=DEAD55EF", rd); end
        model_access(1'b1, 32'h102, 32'h00007A7A, 3'b001, erd, eer);
        access(1'b1, 32'h102, 32'h00007A7A, 3'b001, rd, er, lat, nr, rdy);
        model_access(1'b0, 32'h100, 32'h0, 3'b010, erd, eer);
        access(1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat, nr, rdy);
        checks++; if (rd !== 32'h7A7A55EF) begin failures++; $display("FAIL sh_then_lw got=%h exp=7A7A55EF", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic er, eer, rdy;
        int lat, nr;
        logic        wes [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ads [4] = '{32'h102, 32'h101, 32'(4 * DEPTH2), 32'h100};
        logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b010, 3'b100};
        model_access(1'b1, 32'(4 * DEPTH2 - 4), 32'h0F0F1234, 3'b010, erd, eer);
        access(1'b1, 32'(4 * DEPTH2 - 4), 32'h0F0F1234, 3'b010, rd, er, lat, nr, rdy);
        for (int i = 0; i < 4; i++) begin
            access(wes[i], ads[i], 32'hFFFFFFFF, f3s[i], rd, er, lat, nr, rdy);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
                failures++;
                $display("FAIL error_%0d got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=3", i, er, rd, lat);
            end
        end
        access(1'b0, 32'(4 * DEPTH2 - 4), 32'h0, 3'b010, rd, er, lat, nr, rdy);
        checks++; if (rd !== 32'h0F0F1234) begin failures++; $display("FAIL last_word_kept got=%h exp=0F0F1234", rd); end
        access(1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat, nr, rdy);
        checks++; if (rd !== 32'h7A7A55EF) begin failures++; $display("FAIL bad_f3_store_kept got=%h exp=7A7A55EF", rd); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd, erd;
        logic er, eer, rdy;
        int lat, nr, seen;
        model_access(1'b1, 32'h200, 32'h11223344, 3'b010, erd, eer);
        access(1'b1, 32'h200, 32'h11223344, 3'b010, rd, er, lat, nr, rdy);
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h200;
        bus2.req_wdata = 32'hCAFEF00D; bus2.req_funct3 = 3'b010;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        checks++;
        if (bus2.req_ready !== 1'b1 || busy2 !== 1'b0 || bus2.resp_valid !== 1'b0 ||
            bus2.resp_rdata !== 32'h0 || bus2.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got ready=%b busy=%b valid=%b rdata=%h err=%b exp 1 0 0 0 0",
                     bus2.req_ready, busy2, bus2.resp_valid, bus2.resp_rdata, bus2.resp_err);
        end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus2.resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_resp got=%0d exp=0", seen); end
        access(1'b0, 32'h200, 32'h0, 3'b010, rd, er, lat, nr, rdy);
        checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL midrst_not_written got=%h exp=11223344", rd); end
    endtask

    task automatic test_accept_reset();
        logic [31:0] rd, erd;
        logic er, eer, rdy;
        int lat, nr, seen;
        model_access(1'b1, 32'h300, 32'h55AA55AA, 3'b010, erd, eer);
        access(1'b1, 32'h300, 32'h55AA55AA, 3'b010, rd, er, lat, nr, rdy);
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h300;
        bus2.req_wdata = 32'h0BADF00D; bus2.req_funct3 = 3'b010;
        rst2 = 1'b1;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        rst2 = 1'b0;
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL accrst_busy got=%b exp=0", busy2); end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus2.resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL accrst_no_resp got=%0d exp=0", seen); end
        access(1'b0, 32'h300, 32'h0, 3'b010, rd, er, lat, nr, rdy);
        checks++; if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL accrst_not_written got=%h exp=55AA55AA", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd;
        logic er, eer, rdy, we;
        logic [2:0] f3;
        int lat, nr, r;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model_access(1'b1, 32'(4 * i), wd, 3'b010, erd, eer);
            access(1'b1, 32'(4 * i), wd, 3'b010, rd, er, lat, nr, rdy);
        end
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            wd = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0)      a = 32'(4 * DEPTH2) + 32'($urandom_range(0, 63));
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else             a = 32'($urandom_range(0, 63));
            model_access(we, a, wd, f3, erd, eer);
            access(we, a, wd, f3, rd, er, lat, nr, rdy);
            checks++;
            if (rd !== erd || er !== eer) begin
                failures++;
                $display("FAIL rand_%0d we=%b f3=%0d addr=%h got rdata=%h err=%b exp rdata=%h err=%b",
                         i, we, f3, a, rd, er, erd, eer);
            end
            checks++;
            if (lat !== 3 || nr !== 1 || rdy !== 1'b1) begin
                failures++;
                $display("FAIL rand_timing_%0d got lat=%0d nresp=%0d ready_ok=%b exp 3 1 1", i, lat, nr, rdy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4];
        logic [32:0] exp_q [$];
        logic [32:0] e;
        int accepts, resps, both, bad_gap, last;
        logic we;
        int idx;
        accepts = 0; resps = 0; both = 0; bad_gap = 0; last = -1;
        for (int cyc = 0; cyc < 63; cyc++) begin
            @(negedge clk);
            if (cyc == 60) bus0.req_valid = 1'b0;
            if (bus0.resp_valid) begin
                resps++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b2b_extra_resp cyc=%0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (bus0.resp_err !== e[32] || bus0.resp_rdata !== e[31:0]) begin
                        failures++;
                        $display("FAIL b2b_data cyc=%0d got=%h err=%b exp=%h err=%b",
                                 cyc, bus0.resp_rdata, bus0.resp_err, e[31:0], e[32]);
                    end
                end
            end
            if (bus0.resp_valid && bus0.req_ready) both++;
            if (bus0.req_ready && cyc < 60) begin
                if (last >= 0 && cyc - last != 2) bad_gap++;
                last = cyc;
                idx = (accepts < 4) ? accepts : $urandom_range(0, 3);
                we  = (accepts < 4) ? 1'b1 : 1'($urandom);
                bus0.req_valid  = 1'b1;
                bus0.req_we     = we;
                bus0.req_addr   = 32'(4 * idx);
                bus0.req_wdata  = $urandom;
                bus0.req_funct3 = 3'b010;
                if (we) begin
                    w[idx] = bus0.req_wdata;
                    exp_q.push_back({1'b0, 32'h0});
                end else begin
                    exp_q.push_back({1'b0, w[idx]});
                end
                accepts++;
            end
        end
        checks++; if (resps !== accepts) begin failures++; $display("FAIL b2b_resp_count got=%0d exp=%0d", resps, accepts); end
        checks++; if (both !== 0) begin failures++; $display("FAIL b2b_valid_and_ready got=%0d exp=0", both); end
        checks++; if (bad_gap !== 0) begin failures++; $display("FAIL b2b_gap got=%0d exp=0", bad_gap); end
        checks++; if (accepts < 29) begin failures++; $display("FAIL b2b_accepts got=%0d exp>=29", accepts); end
    endtask

    initial begin
        test_reset();
        test_store_timing();
        test_loads();
        test_sub_word_stores();
        test_errors();
        test_mid_reset();
        test_accept_reset();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder for the pipelined RISC-V core's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs RV32I byte, half and word stores with lane selection, and returns sign- or zero-extended load data with an error flag. It sits on the memory side of the core's MEM stage; the core's hazard logic stalls on `req_ready` and `resp_valid`.

Parameters:
- `DEPTH`, 1024: storage size in 32-bit words; legal byte addresses are 0 .. 4*DEPTH-1.
- `WAIT_CYCLES`, 2: wait states between accept and response; 0 is legal.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the byte/half is taken from the low bits.
- `req_funct3`  in  3  access size and sign, per RV32I funct3 encoding.
- `req_ready`  out  1  responder can accept a request this cycle.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load result; valid only while `resp_valid`=1.
- `resp_err`  out  1  access faulted; valid only while `resp_valid`=1.
- `busy`  out  1  a request is in flight (FSM not in IDLE).

Behaviour:
- Reset:
  - FSM goes to IDLE, wait counter = 0.
  - `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0.
  - Storage array is NOT cleared; contents persist across `rst`.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - Accept on `req_valid` & `req_ready` at a rising edge; latch we, addr, wdata, funct3.
  - Next state: WAIT with counter = `WAIT_CYCLES` if `WAIT_CYCLES`>0, else RESP.
- WAIT:
  - `req_ready`=0; counter decrements each cycle.
  - On the cycle counter = 1, next state is RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle, `req_ready`=0; next state is IDLE.
  - No request can be accepted in the same cycle as `resp_valid`.
- Latency: `resp_valid` rises `WAIT_CYCLES`+1 cycles after the accept edge. Throughput is one request per `WAIT_CYCLES`+2 cycles.
- Commit point: store write and load read both occur on the edge entering RESP, using the latched request.
- Legal funct3:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
- Error conditions, any of which sets `resp_err`=1, forces `resp_rdata`=0 and suppresses the write:
  - any other funct3 for the given direction;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr ≥ 4*`DEPTH`.
- Word index = addr[31:2] (after the range check). Byte lane = addr[1:0]; half lane = addr[1].
- Stores:
  - sb writes only the addressed byte with `wdata`[7:0].
  - sh writes only the addressed half with `wdata`[15:0].
  - sw writes the whole word.
  - All other bytes are unchanged.
- Loads:
  - The selected byte/half is placed at bit 0.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
  - Stores return `resp_rdata`=0.
- Input changes after accept are ignored; the latched copy is used.
- Mid-operation reset:
  - `rst` in WAIT or RESP abandons the request with no response strobe.
  - A store is not written unless its RESP-entry edge already occurred.
  - `rst` on the accept edge wins and nothing is latched.
- `busy`=1 in WAIT and RESP.

Test Plan:
- Reset, `WAIT_CYCLES`=2: sw addr 0x100 data 0xDEADBEEF → accept at edge T, `resp_valid`=1 only in cycle T+3, `resp_err`=0, `req_ready`=0 during T+1..T+3.
- Loads after the above store:
  - lw 0x100 → 0xDEADBEEF
  - lb 0x103 → 0xFFFFFFDE
  - lbu 0x103 → 0x000000DE
  - lh 0x102 → 0xFFFFDEAD
  - lhu 0x100 → 0x0000BEEF
- sb 0x101 data 0x12345655 then lw 0x100 → 0xDEAD55EF. Then sh 0x102 data 0x00007A7A then lw 0x100 → 0x7A7A55EF.
- Error cases, each → `resp_err`=1, `resp_rdata`=0:
  - lw 0x102;
  - lh 0x101;
  - sw 4*`DEPTH`, followed by lw of the last word, which shows that word unchanged;
  - store with funct3=100.
- `rst` pulsed during WAIT of sw 0x200 data 0xCAFEF00D → no `resp_valid`, outputs return to reset values. A following lw 0x200 returns the prior contents, not 0xCAFEF00D.
- `req_valid` held high continuously with `WAIT_CYCLES`=0 → accepts every 2 cycles. `resp_valid` and `req_ready` never both 1; exactly one response per accept.
